switch_debounce: RTL and testbench
==================================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: number of independent switch channels, legal range 1..32.
REQ-002 The block SHALL have parameter TICK_DIV, default 50000: clk cycles per debounce tick (1 ms at 50 MHz), legal range >=1.
REQ-003 The block SHALL have parameter DEBOUNCE_TICKS, default 20: consecutive ticks a new level must persist before acceptance, legal range >=1.
REQ-004 The block SHALL have parameter RESET_VAL, default all-zero, WIDTH bits: post-reset value of the synchronisers and sw_out.
REQ-005 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port sw_raw, input, WIDTH bits: raw asynchronous, bouncing switch pins.
REQ-008 The block SHALL have port sw_out, output, WIDTH bits: registered debounced levels that drive the switch PIO in_port directly.
REQ-009 The block SHALL have port sw_change, output, WIDTH bits, present only with the macro in REQ-023: per-channel change pulse.
REQ-010 The block SHALL have port any_change, output, 1 bit, present only with the macro in REQ-023: OR of sw_change.

Function
REQ-011 Each channel SHALL pass sw_raw through a 2-flop synchroniser (sync1, then sync2); only sync2 SHALL feed the debounce logic.
REQ-012 A shared prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be high for exactly one cycle, when prescaler == TICK_DIV-1; TICK_DIV=1 SHALL give tick high every cycle.
REQ-013 Each channel SHALL have a counter of width clog2(DEBOUNCE_TICKS+1), minimum 1 bit, that never exceeds DEBOUNCE_TICKS-1.
REQ-014 On any cycle with sync2[i] == sw_out[i], the counter SHALL clear to 0 regardless of tick.
REQ-015 When sync2[i] != sw_out[i] and tick is high, the counter SHALL increment if it is below DEBOUNCE_TICKS-1. If it equals DEBOUNCE_TICKS-1, sw_out[i] SHALL load sync2[i] and the counter SHALL clear.
REQ-016 When sync2[i] != sw_out[i] and tick is low, the counter SHALL hold.
REQ-017 A level held stably on sw_raw SHALL appear on sw_out no earlier than the ((DEBOUNCE_TICKS-1)*TICK_DIV+3)th and no later than the (DEBOUNCE_TICKS*TICK_DIV+2)th rising edge after the change, counting the first capturing edge as 1. With TICK_DIV=1, this SHALL be exactly the (DEBOUNCE_TICKS+2)th edge.
REQ-018 Any return of sync2[i] to sw_out[i] before acceptance SHALL discard the accumulated count; a bounce SHALL therefore never partially count toward a later transition.
REQ-019 Channels SHALL be fully independent: simultaneous transitions on several bits SHALL each resolve on their own timing, and a change on one bit SHALL NOT disturb another bit's counter.
REQ-020 The block SHALL be free-running: no handshake, no back-pressure, and sw_out valid every cycle.

Reset
REQ-021 While reset_n is low, sync1, sync2 and sw_out SHALL equal RESET_VAL, and the prescaler, all channel counters, sw_change and any_change SHALL equal 0, asynchronously.
REQ-022 Reset asserted mid-count SHALL abandon the pending transition. After release, the prescaler SHALL restart from 0, and a sw_raw differing from RESET_VAL SHALL be accepted only after a full REQ-017 latency.

Configuration
REQ-023 Macro SWITCH_DEBOUNCE_EVENT_EN SHALL compile in sw_change and any_change. sw_change[i] SHALL be registered and high for exactly one cycle, the same cycle sw_out[i] first shows its new value; any_change SHALL be registered, the same cycle as sw_change.
REQ-024 Without SWITCH_DEBOUNCE_EVENT_EN, sw_change, any_change and their registers SHALL be absent, and sw_out behaviour SHALL be identical.

Verification
REQ-025 WIDTH=4, TICK_DIV=1, DEBOUNCE_TICKS=3, reset then sw_raw 0x0 to 0x1 held -> sw_out 0x1 on the 5th edge after the change, and sw_change=0x1 and any_change=1 for that one cycle only.
REQ-026 Same params, sw_raw[0] high for 2 cycles then low -> sw_out stays 0x0 and no sw_change. sw_raw[0] high for 3 cycles -> sw_out[0] rises, then falls after a further stable-low latency.
REQ-027 Same params, sw_raw 0x0 to 0xF on one edge -> all four bits of sw_out and sw_change update in the same cycle. Toggling bit 2 every cycle afterwards -> sw_out[2] holds and bits 0, 1, 3 are unaffected.
REQ-028 TICK_DIV=4, DEBOUNCE_TICKS=3, change applied at each prescaler phase 0..3 -> acceptance edge always within [11, 14].
REQ-029 Reset_n pulsed low with a counter at 2 of 3 -> sw_out returns to RESET_VAL at once. After release with sw_raw held at the new value -> sw_out updates only after the full latency.
REQ-030 Macro undefined -> netlist has no sw_change or any_change, and the REQ-025 to REQ-029 sw_out waveforms are unchanged.

Source files
------------

// File: rtl/switch_debounce.sv
// Multi-channel switch debouncer: 2-flop synchroniser, shared tick prescaler, per-channel stability counter.
// Define SWITCH_DEBOUNCE_EVENT_EN to add the registered sw_change / any_change event outputs.
module switch_debounce #(
  parameter int               WIDTH          = 4,
  parameter int               TICK_DIV       = 50000,
  parameter int               DEBOUNCE_TICKS = 20,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out
`ifdef SWITCH_DEBOUNCE_EVENT_EN
  ,
  output logic [WIDTH-1:0] sw_change,
  output logic             any_change
`endif
);

  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W_RAW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int CNT_W    = (CNT_W_RAW > 0) ? CNT_W_RAW : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [PRE_W-1:0]            r_presc;
  logic                        w_tick;
  logic [WIDTH-1:0]            r_sync1;
  logic [WIDTH-1:0]            r_sync2;
  logic [WIDTH-1:0]            r_out;
  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]            w_differs;
  logic [WIDTH-1:0]            w_accept;

  // Shared prescaler; with TICK_DIV=1 it stays at 0 and tick is permanently high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (r_presc == PRE_MAX) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick = (r_presc == PRE_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_differs = r_sync2 ^ r_out;
    w_accept  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = w_differs[i] && w_tick && (r_cnt[i] == CNT_MAX);
    end
  end

  // Any cycle where the synchronised level matches the output wipes the count, so bounces never accumulate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_out <= RESET_VAL;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_differs[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_cnt[i] <= '0;
          r_out[i] <= r_sync2[i];
        end else if (w_tick) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sw_out = r_out;

`ifdef SWITCH_DEBOUNCE_EVENT_EN
  logic [WIDTH-1:0] r_change;
  logic             r_any;

  // Registered from the same accept term that loads r_out, so the pulse aligns with the new level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_change <= '0;
      r_any    <= 1'b0;
    end else begin
      r_change <= w_accept;
      r_any    <= |w_accept;
    end
  end

  assign sw_change  = r_change;
  assign any_change = r_any;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce: fast instance (TICK_DIV=1) and prescaled instance (TICK_DIV=4).
module tb_switch_debounce;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] raw_a = 4'h0;
  logic [3:0] raw_b = 4'hA;
  logic [3:0] out_a;
  logic [3:0] out_b;
`ifdef SWITCH_DEBOUNCE_EVENT_EN
  logic [3:0] chg_a;
  logic [3:0] chg_b;
  logic       any_a;
  logic       any_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  switch_debounce #(
    .WIDTH(4), .TICK_DIV(1), .DEBOUNCE_TICKS(3), .RESET_VAL(4'h0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .sw_raw(raw_a), .sw_out(out_a)
`ifdef SWITCH_DEBOUNCE_EVENT_EN
    , .sw_change(chg_a), .any_change(any_a)
`endif
  );

  switch_debounce #(
    .WIDTH(4), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .RESET_VAL(4'hA)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .sw_raw(raw_b), .sw_out(out_b)
`ifdef SWITCH_DEBOUNCE_EVENT_EN
    , .sw_change(chg_b), .any_change(any_b)
`endif
  );

  task automatic test_reset();
    reset_n = 1'b0;
    raw_a   = 4'h0;
    raw_b   = 4'hA;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (out_a !== 4'h0) begin
      n_err++; $display("FAIL reset_out_a: got %h expected %h", out_a, 4'h0);
    end
    n_vec++;
    if (out_b !== 4'hA) begin
      n_err++; $display("FAIL reset_out_b: got %h expected %h", out_b, 4'hA);
    end
`ifdef SWITCH_DEBOUNCE_EVENT_EN
    n_vec++;
    if (chg_a !== 4'h0 || any_a !== 1'b0) begin
      n_err++; $display("FAIL reset_events_a: got %h/%b expected 0/0", chg_a, any_a);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (out_b !== 4'hA) begin
      n_err++; $display("FAIL post_reset_out_b: got %h expected %h", out_b, 4'hA);
    end
  endtask

  task automatic test_single_rise();
    logic [3:0] exp_out;
    raw_a = 4'h1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      exp_out = (k >= 5) ? 4'h1 : 4'h0;
      n_vec++;
      if (out_a !== exp_out) begin
        n_err++; $display("FAIL rise_out edge %0d: got %h expected %h", k, out_a, exp_out);
      end
`ifdef SWITCH_DEBOUNCE_EVENT_EN
      n_vec++;
      if (chg_a !== ((k == 5) ? 4'h1 : 4'h0) || any_a !== (k == 5)) begin
        n_err++; $display("FAIL rise_event edge %0d: got %h/%b expected %h/%b",
                          k, chg_a, any_a, (k == 5) ? 4'h1 : 4'h0, (k == 5));
      end
`endif
    end
    raw_a = 4'h0;
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (out_a !== 4'h0) begin
      n_err++; $display("FAIL rise_return: got %h expected %h", out_a, 4'h0);
    end
  endtask

  task automatic test_glitch();
    logic [3:0] exp_out;
    logic [3:0] exp_chg;
    // Two-cycle pulse must be rejected entirely.
    raw_a = 4'h1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) raw_a = 4'h0;
      n_vec++;
      if (out_a !== 4'h0) begin
        n_err++; $display("FAIL glitch2_out edge %0d: got %h expected %h", k, out_a, 4'h0);
      end
`ifdef SWITCH_DEBOUNCE_EVENT_EN
      n_vec++;
      if (chg_a !== 4'h0) begin
        n_err++; $display("FAIL glitch2_event edge %0d: got %h expected %h", k, chg_a, 4'h0);
      end
`endif
    end
    // Three-cycle pulse is accepted at edge 5, then the low level is accepted at edge 8.
    raw_a = 4'h1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 3) raw_a = 4'h0;
      exp_out = (k >= 5 && k <= 7) ? 4'h1 : 4'h0;
      exp_chg = (k == 5 || k == 8) ? 4'h1 : 4'h0;
      n_vec++;
      if (out_a !== exp_out) begin
        n_err++; $display("FAIL pulse3_out edge %0d: got %h expected %h", k, out_a, exp_out);
      end
`ifdef SWITCH_DEBOUNCE_EVENT_EN
      n_vec++;
      if (chg_a !== exp_chg) begin
        n_err++; $display("FAIL pulse3_event edge %0d: got %h expected %h", k, chg_a, exp_chg);
      end
`else
      exp_chg = 4'h0;
`endif
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_out;
    raw_a = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      exp_out = (k == 5) ? 4'hF : 4'h0;
      n_vec++;
      if (out_a !== exp_out) begin
        n_err++; $display("FAIL all_rise_out edge %0d: got %h expected %h", k, out_a, exp_out);
      end
`ifdef SWITCH_DEBOUNCE_EVENT_EN
      n_vec++;
      if (chg_a !== exp_out || any_a !== (k == 5)) begin
        n_err++; $display("FAIL all_rise_event edge %0d: got %h/%b expected %h/%b",
                          k, chg_a, any_a, exp_out, (k == 5));
      end
`endif
    end
    for (int k = 1; k <= 12; k++) begin
      raw_a[2] = ~raw_a[2];
      @(posedge clk); #1;
      n_vec++;
      if (out_a !== 4'hF) begin
        n_err++; $display("FAIL toggle_out cycle %0d: got %h expected %h", k, out_a, 4'hF);
      end
`ifdef SWITCH_DEBOUNCE_EVENT_EN
      n_vec++;
      if (chg_a !== 4'h0) begin
        n_err++; $display("FAIL toggle_event cycle %0d: got %h expected %h", k, chg_a, 4'h0);
      end
`endif
    end
    raw_a = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    raw_a = 4'hB;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      exp_out = (k == 5) ? 4'hB : 4'hF;
      n_vec++;
      if (out_a !== exp_out) begin
        n_err++; $display("FAIL bit2_fall_out edge %0d: got %h expected %h", k, out_a, exp_out);
      end
`ifdef SWITCH_DEBOUNCE_EVENT_EN
      n_vec++;
      if (chg_a !== ((k == 5) ? 4'h4 : 4'h0)) begin
        n_err++; $display("FAIL bit2_fall_event edge %0d: got %h expected %h",
                          k, chg_a, (k == 5) ? 4'h4 : 4'h0);
      end
`endif
    end
  endtask

  task automatic test_reset_midcount();
    logic [3:0] exp_out;
    raw_a = 4'h4;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_a !== 4'hB) begin
        n_err++; $display("FAIL pre_reset_out edge %0d: got %h expected %h", k, out_a, 4'hB);
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (out_a !== 4'h0) begin
      n_err++; $display("FAIL async_reset_out_a: got %h expected %h", out_a, 4'h0);
    end
    n_vec++;
    if (out_b !== 4'hA) begin
      n_err++; $display("FAIL async_reset_out_b: got %h expected %h", out_b, 4'hA);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      exp_out = (k >= 5) ? 4'h4 : 4'h0;
      n_vec++;
      if (out_a !== exp_out) begin
        n_err++; $display("FAIL post_reset_out edge %0d: got %h expected %h", k, out_a, exp_out);
      end
`ifdef SWITCH_DEBOUNCE_EVENT_EN
      n_vec++;
      if (chg_a !== ((k == 5) ? 4'h4 : 4'h0)) begin
        n_err++; $display("FAIL post_reset_event edge %0d: got %h expected %h",
                          k, chg_a, (k == 5) ? 4'h4 : 4'h0);
      end
`endif
    end
  endtask

  task automatic test_prescaler_phase();
    int exp_edge[4] = '{12, 11, 14, 13};
    int found;
    int pulses;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      reset_n = 1'b0;
      raw_b   = 4'hA;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (p) @(posedge clk);
      #1;
      raw_b  = 4'hB;
      found  = 0;
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (found == 0 && out_b === 4'hB) found = k;
`ifdef SWITCH_DEBOUNCE_EVENT_EN
        if (chg_b !== 4'h0) pulses++;
`endif
      end
      n_vec++;
      if (found != exp_edge[p]) begin
        n_err++; $display("FAIL phase%0d_accept_edge: got %0d expected %0d", p, found, exp_edge[p]);
      end
`ifdef SWITCH_DEBOUNCE_EVENT_EN
      n_vec++;
      if (pulses != 1) begin
        n_err++; $display("FAIL phase%0d_event_count: got %0d expected 1", p, pulses);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_simultaneous();
    test_reset_midcount();
    test_prescaler_phase();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
